// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiply execution unit.
// MULT_HI_EN widens the product to carry the upper DATA_W bits.
package mult_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int PHY_W  = 6;

`ifdef MULT_HI_EN
    localparam int PROD_W = 2 * DATA_W;
`else
    localparam int PROD_W = DATA_W;
`endif

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] robtag;
        logic [PHY_W-1:0] rdphy;
        logic             regwrite;
    } mult_tag_t;

    // True when tag sits deeper in the ROB than the flushing branch.
    // The modular subtraction keeps this correct across pointer wrap.
    function automatic logic rob_younger(
        input logic [TAG_W-1:0] tag,
        input logic [TAG_W-1:0] top,
        input logic [TAG_W-1:0] depth
    );
        logic [TAG_W-1:0] diff;
        diff = tag - top;
        return diff > depth;
    endfunction

    // Low DATA_W bits are sign-independent, so the narrow build
    // uses a plain unsigned multiply; the wide build sign-extends.
    function automatic logic [PROD_W-1:0] mult_prod(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
`ifdef MULT_HI_EN
        logic [2*DATA_W-1:0] ea;
        logic [2*DATA_W-1:0] eb;
        ea = {{DATA_W{a[DATA_W-1]}}, a};
        eb = {{DATA_W{b[DATA_W-1]}}, b};
        return ea * eb;
`else
        return a * b;
`endif
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One register stage of the multiply pipeline with flush kill.
// DO_MUL selects the stage that turns operands into the product.
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int IN_W   = 2 * DATA_W,
    parameter int OUT_W  = 2 * DATA_W,
    parameter bit DO_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  mult_tag_t        in_tag,
    input  logic [IN_W-1:0]  in_pay,
    input  logic             flush,
    input  logic [TAG_W-1:0] top,
    input  logic [TAG_W-1:0] depth,
    output mult_tag_t        out_tag,
    output logic [OUT_W-1:0] out_pay
);

    logic             live_in;
    logic [OUT_W-1:0] calc;
    mult_tag_t        tag_d;
    mult_tag_t        tag_q;
    logic [OUT_W-1:0] pay_d;
    logic [OUT_W-1:0] pay_q;

    generate
        if (DO_MUL) begin : g_mul
            assign calc = mult_prod(in_pay[2*DATA_W-1:DATA_W],
                                    in_pay[DATA_W-1:0]);
        end else begin : g_pass
            assign calc = in_pay;
        end
    endgenerate

    // Drop the incoming entry if the flush kills it; bubbles keep payload.
    always_comb begin
        live_in = in_tag.valid
                  && !(flush && rob_younger(in_tag.robtag, top, depth));
        tag_d       = tag_q;
        tag_d.valid = 1'b0;
        pay_d       = pay_q;
        if (live_in) begin
            tag_d = in_tag;
            pay_d = calc;
        end
    end

    // Stage register, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            pay_q <= '0;
        end else begin
            tag_q <= tag_d;
            pay_q <= pay_d;
        end
    end

    assign out_tag = tag_q;
    assign out_pay = pay_q;

endmodule

// File: rtl/mult_exec_unit.sv
// Fixed-latency non-stalling multiply unit feeding a reserved CDB slot.
// Define MULT_HI_EN to add the Mul_DataHi upper-product output.
module mult_exec_unit
    import mult_pkg::*;
#(
    parameter int STAGES = 4
) (
    input  logic              Clk,
    input  logic              Resetb,
    input  logic              Iss_Mult,
    input  logic [PHY_W-1:0]  Iss_RdPhyAddrMul,
    input  logic [TAG_W-1:0]  Iss_RobTagMul,
    input  logic              Iss_RegWriteMul,
    input  logic [DATA_W-1:0] PhyReg_MultRsData,
    input  logic [DATA_W-1:0] PhyReg_MultRtData,
    input  logic              Cdb_Flush,
    input  logic [TAG_W-1:0]  Rob_TopPtr,
    input  logic [TAG_W-1:0]  Cdb_RobDepth,
    output logic              Mul_Done,
    output logic [DATA_W-1:0] Mul_Data,
    output logic [PHY_W-1:0]  Mul_RdPhyAddr,
    output logic [TAG_W-1:0]  Mul_RobTag,
    output logic              Mul_RegWrite,
`ifdef MULT_HI_EN
    output logic [DATA_W-1:0] Mul_DataHi,
`endif
    output logic              Mul_Busy
);

    mult_tag_t           iss_tag;
    mult_tag_t           tag_s  [1:STAGES];
    logic                live_s [1:STAGES];
    logic [2*DATA_W-1:0] ops_s1;
    logic [PROD_W-1:0]   pay_s  [2:STAGES];

    assign iss_tag.valid    = Iss_Mult;
    assign iss_tag.robtag   = Iss_RobTagMul;
    assign iss_tag.rdphy    = Iss_RdPhyAddrMul;
    assign iss_tag.regwrite = Iss_RegWriteMul;

    // S1 only registers the operands; no arithmetic before the flop.
    mult_pipe_stage #(
        .IN_W  (2 * DATA_W),
        .OUT_W (2 * DATA_W),
        .DO_MUL(1'b0)
    ) u_s1 (
        .clk    (Clk),
        .rst_n  (Resetb),
        .in_tag (iss_tag),
        .in_pay ({PhyReg_MultRsData, PhyReg_MultRtData}),
        .flush  (Cdb_Flush),
        .top    (Rob_TopPtr),
        .depth  (Cdb_RobDepth),
        .out_tag(tag_s[1]),
        .out_pay(ops_s1)
    );

    generate
        for (genvar k = 2; k <= STAGES; k++) begin : g_stage
            if (k == 2) begin : g_mul
                mult_pipe_stage #(
                    .IN_W  (2 * DATA_W),
                    .OUT_W (PROD_W),
                    .DO_MUL(1'b1)
                ) u_stage (
                    .clk    (Clk),
                    .rst_n  (Resetb),
                    .in_tag (tag_s[k-1]),
                    .in_pay (ops_s1),
                    .flush  (Cdb_Flush),
                    .top    (Rob_TopPtr),
                    .depth  (Cdb_RobDepth),
                    .out_tag(tag_s[k]),
                    .out_pay(pay_s[k])
                );
            end else begin : g_pass
                mult_pipe_stage #(
                    .IN_W  (PROD_W),
                    .OUT_W (PROD_W),
                    .DO_MUL(1'b0)
                ) u_stage (
                    .clk    (Clk),
                    .rst_n  (Resetb),
                    .in_tag (tag_s[k-1]),
                    .in_pay (pay_s[k-1]),
                    .flush  (Cdb_Flush),
                    .top    (Rob_TopPtr),
                    .depth  (Cdb_RobDepth),
                    .out_tag(tag_s[k]),
                    .out_pay(pay_s[k])
                );
            end
        end
    endgenerate

    // Per-stage validity after this cycle's flush, and their OR.
    always_comb begin
        Mul_Busy = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            live_s[k] = tag_s[k].valid
                        && !(Cdb_Flush
                             && rob_younger(tag_s[k].robtag,
                                            Rob_TopPtr,
                                            Cdb_RobDepth));
            Mul_Busy = Mul_Busy | live_s[k];
        end
    end

    assign Mul_Done      = live_s[STAGES];
    assign Mul_Data      = pay_s[STAGES][DATA_W-1:0];
    assign Mul_RdPhyAddr = tag_s[STAGES].rdphy;
    assign Mul_RobTag    = tag_s[STAGES].robtag;
    assign Mul_RegWrite  = tag_s[STAGES].regwrite;
`ifdef MULT_HI_EN
    assign Mul_DataHi    = pay_s[STAGES][2*DATA_W-1:DATA_W];
`endif

endmodule

// File: tb/tb_mult_exec_unit.sv
// Randomized self-checking bench for mult_exec_unit.
// Reference: list of in-flight ops with due cycles and flush filtering.
module tb_mult_exec_unit;

    localparam int STAGES = 4;

    logic        Clk;
    logic        Resetb;
    logic        Iss_Mult;
    logic [5:0]  Iss_RdPhyAddrMul;
    logic [4:0]  Iss_RobTagMul;
    logic        Iss_RegWriteMul;
    logic [31:0] PhyReg_MultRsData;
    logic [31:0] PhyReg_MultRtData;
    logic        Cdb_Flush;
    logic [4:0]  Rob_TopPtr;
    logic [4:0]  Cdb_RobDepth;
    logic        Mul_Done;
    logic [31:0] Mul_Data;
    logic [5:0]  Mul_RdPhyAddr;
    logic [4:0]  Mul_RobTag;
    logic        Mul_RegWrite;
    logic        Mul_Busy;
`ifdef MULT_HI_EN
    logic [31:0] Mul_DataHi;
`endif

    mult_exec_unit #(.STAGES(STAGES)) dut (
        .Clk              (Clk),
        .Resetb           (Resetb),
        .Iss_Mult         (Iss_Mult),
        .Iss_RdPhyAddrMul (Iss_RdPhyAddrMul),
        .Iss_RobTagMul    (Iss_RobTagMul),
        .Iss_RegWriteMul  (Iss_RegWriteMul),
        .PhyReg_MultRsData(PhyReg_MultRsData),
        .PhyReg_MultRtData(PhyReg_MultRtData),
        .Cdb_Flush        (Cdb_Flush),
        .Rob_TopPtr       (Rob_TopPtr),
        .Cdb_RobDepth     (Cdb_RobDepth),
        .Mul_Done         (Mul_Done),
        .Mul_Data         (Mul_Data),
        .Mul_RdPhyAddr    (Mul_RdPhyAddr),
        .Mul_RobTag       (Mul_RobTag),
        .Mul_RegWrite     (Mul_RegWrite),
`ifdef MULT_HI_EN
        .Mul_DataHi       (Mul_DataHi),
`endif
        .Mul_Busy         (Mul_Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          due;
        logic [4:0]  tag;
        logic [5:0]  rd;
        logic        rw;
        logic [63:0] prod;
    } ent_t;

    ent_t        q[$];
    int          cyc;
    int          n_tests;
    int          n_fail;
    logic [63:0] hold_prod;
    logic [4:0]  hold_tag;
    logic [5:0]  hold_rd;
    logic        hold_rw;
    bit          hold_known;

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     name, cyc, got, exp);
        end
    endtask

    function automatic bit younger(input logic [4:0] tag,
                                   input logic [4:0] top,
                                   input logic [4:0] dep);
        int d;
        d = (int'(tag) - int'(top) + 32) % 32;
        return d > int'(dep);
    endfunction

    function automatic logic [63:0] smul(input logic [31:0] a,
                                         input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic model_reset();
        q.delete();
        hold_prod  = '0;
        hold_tag   = '0;
        hold_rd    = '0;
        hold_rw    = 1'b0;
        hold_known = 1'b1;
    endtask

    task automatic step(input bit iss,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [5:0] rd,
                        input bit rw, input bit fl,
                        input logic [4:0] top, input logic [4:0] dep);
        ent_t nq[$];
        ent_t hit;
        ent_t ne;
        bit   exp_done;
        bit   exp_busy;
        bit   last_kill;
        @(posedge Clk);
        #1;
        Iss_Mult          = iss;
        PhyReg_MultRsData = a;
        PhyReg_MultRtData = b;
        Iss_RobTagMul     = tag;
        Iss_RdPhyAddrMul  = rd;
        Iss_RegWriteMul   = rw;
        Cdb_Flush         = fl;
        Rob_TopPtr        = top;
        Cdb_RobDepth      = dep;
        cyc++;
        @(negedge Clk);
        exp_done  = 1'b0;
        exp_busy  = 1'b0;
        last_kill = 1'b0;
        hit       = '{0, '0, '0, 1'b0, '0};
        foreach (q[i]) begin
            if (fl && younger(q[i].tag, top, dep)) begin
                if (q[i].due == cyc) last_kill = 1'b1;
            end else begin
                exp_busy = 1'b1;
                if (q[i].due == cyc) begin
                    exp_done = 1'b1;
                    hit      = q[i];
                end else begin
                    nq.push_back(q[i]);
                end
            end
        end
        check("done", 64'(Mul_Done), 64'(exp_done));
        check("busy", 64'(Mul_Busy), 64'(exp_busy));
        if (exp_done) begin
            hold_prod  = hit.prod;
            hold_tag   = hit.tag;
            hold_rd    = hit.rd;
            hold_rw    = hit.rw;
            hold_known = 1'b1;
        end else if (last_kill) begin
            hold_known = 1'b0;
        end
        if (exp_done || hold_known) begin
            check("data", 64'(Mul_Data), 64'(hold_prod[31:0]));
            check("tag", 64'(Mul_RobTag), 64'(hold_tag));
            check("rd", 64'(Mul_RdPhyAddr), 64'(hold_rd));
            check("rw", 64'(Mul_RegWrite), 64'(hold_rw));
`ifdef MULT_HI_EN
            check("datahi", 64'(Mul_DataHi), 64'(hold_prod[63:32]));
`endif
        end
        if (iss && !(fl && younger(tag, top, dep))) begin
            ne = '{cyc + STAGES, tag, rd, rw, smul(a, b)};
            nq.push_back(ne);
        end
        q = nq;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        cyc               = 0;
        Resetb            = 1'b0;
        Iss_Mult          = 1'b0;
        Iss_RdPhyAddrMul  = '0;
        Iss_RobTagMul     = '0;
        Iss_RegWriteMul   = 1'b0;
        PhyReg_MultRsData = '0;
        PhyReg_MultRtData = '0;
        Cdb_Flush         = 1'b0;
        Rob_TopPtr        = '0;
        Cdb_RobDepth      = '0;
        model_reset();
        #3;
        check("rst_done", 64'(Mul_Done), 64'd0);
        check("rst_busy", 64'(Mul_Busy), 64'd0);
        check("rst_data", 64'(Mul_Data), 64'd0);
        check("rst_tag", 64'(Mul_RobTag), 64'd0);
        check("rst_rd", 64'(Mul_RdPhyAddr), 64'd0);
        check("rst_rw", 64'(Mul_RegWrite), 64'd0);
`ifdef MULT_HI_EN
        check("rst_datahi", 64'(Mul_DataHi), 64'd0);
`endif
        #9 Resetb = 1'b1;

        // single multiply issued in cycle 10, result in cycle 14
        idle(9);
        step(1, 32'd7, 32'd6, 5'd3, 6'd12, 1, 0, 0, 0);
        idle(4);
        check("t1_done", 64'(Mul_Done), 64'd1);
        check("t1_data", 64'(Mul_Data), 64'd42);
        check("t1_tag", 64'(Mul_RobTag), 64'd3);
        check("t1_rd", 64'(Mul_RdPhyAddr), 64'd12);
        idle(2);

        // back-to-back signed corner operands
        step(1, 32'hFFFFFFFD, 32'd5, 5'd1, 6'd1, 1, 0, 0, 0);
        step(1, 32'h00010000, 32'h00010000, 5'd2, 6'd2, 0, 0, 0, 0);
        step(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 6'd3, 1, 0, 0, 0);
        step(1, 32'h7FFFFFFF, 32'd2, 5'd4, 6'd4, 1, 0, 0, 0);
        idle(3);
        check("b2b_d3", 64'(Mul_Data), 64'h1);
        idle(1);
        check("b2b_d4", 64'(Mul_Data), 64'hFFFFFFFE);
        idle(2);

        // wrapped ROB flush: tags 31 and 0 survive, tag 2 dies
        step(1, 32'd3, 32'd3, 5'd31, 6'd5, 1, 0, 5'd30, 0);
        step(1, 32'd4, 32'd4, 5'd0, 6'd6, 1, 0, 5'd30, 0);
        step(1, 32'd5, 32'd5, 5'd2, 6'd7, 1, 0, 5'd30, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd30, 5'd2);
        idle(6);

        // kill in the last stage during its done cycle
        step(1, 32'd11, 32'd13, 5'd9, 6'd9, 1, 0, 5'd5, 5'd1);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd1);
        check("last_kill", 64'(Mul_Done), 64'd0);
        idle(2);

        // issue killed in the same cycle as the flush
        step(1, 32'd2, 32'd9, 5'd6, 6'd10, 1, 1, 5'd0, 5'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("iss_kill_busy", 64'(Mul_Busy), 64'd0);
        end

        // reset pulse with three entries in flight
        step(1, 32'd21, 32'd2, 5'd11, 6'd11, 1, 0, 0, 0);
        step(1, 32'd22, 32'd2, 5'd12, 6'd12, 1, 0, 0, 0);
        step(1, 32'd23, 32'd2, 5'd13, 6'd13, 1, 0, 0, 0);
        @(posedge Clk);
        #1;
        Resetb   = 1'b0;
        Iss_Mult = 1'b0;
        Cdb_Flush = 1'b0;
        cyc++;
        #1;
        check("rstp_done", 64'(Mul_Done), 64'd0);
        check("rstp_busy", 64'(Mul_Busy), 64'd0);
        model_reset();
        @(negedge Clk);
        #1 Resetb = 1'b1;
        idle(6);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom, $urandom,
                 5'($urandom), 6'($urandom), 1'($urandom),
                 $urandom_range(0, 9) == 0,
                 5'($urandom), 5'($urandom));
        end
        idle(STAGES + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_exec_unit.md
Name: mult_exec_unit

Overview:
- Execution-side consumer of the multiply issue port.
- Accepts one issued multiply per cycle (Iss_Mult plus tag fields from the mult issue queue, operand data from the physical register file).
- Multiplies through a fixed-latency, non-stalling pipeline and presents the result, tag and destination for the CDB slot reserved by the issue unit.
- Kills in-flight entries younger than a mispredicted branch on Cdb_Flush.

Parameters:
- DATA_W, 32, operand and result width.
- STAGES, 4, pipeline depth; issue-to-result latency in cycles (min 2).
- TAG_W, 5, ROB tag / pointer / depth width.
- PHY_W, 6, physical register address width.

Ports:
- Clk  in  1  clock, rising edge.
- Resetb  in  1  asynchronous active-low reset.
- Iss_Mult  in  1  issue grant; the fields below are valid this cycle.
- Iss_RdPhyAddrMul  in  PHY_W  destination physical register.
- Iss_RobTagMul  in  TAG_W  ROB tag.
- Iss_RegWriteMul  in  1  result writes the register file.
- PhyReg_MultRsData  in  DATA_W  Rs operand (read with Iss_RsPhyAddrMul, same cycle).
- PhyReg_MultRtData  in  DATA_W  Rt operand.
- Cdb_Flush  in  1  branch mispredict flush.
- Rob_TopPtr  in  TAG_W  ROB head pointer.
- Cdb_RobDepth  in  TAG_W  depth of the flushing branch relative to head.
- Mul_Done  out  1  result valid this cycle.
- Mul_Data  out  DATA_W  low DATA_W bits of Rs*Rt.
- Mul_RdPhyAddr  out  PHY_W  destination.
- Mul_RobTag  out  TAG_W  tag.
- Mul_RegWrite  out  1  register-write flag.
- Mul_Busy  out  1  OR of all stage valids after flush.

Behaviour:
- Reset (async, Resetb low): all stage valid bits 0, so Mul_Done=0 and Mul_Busy=0. Data, tag, addr and RegWrite outputs = 0. Reset mid-operation discards all in-flight entries immediately.
- Pipeline: stage registers S1..S(STAGES), each holding valid, tag, rd, regwrite and partial product state.
- An Iss_Mult in cycle N is captured into S1 at the edge ending cycle N. It reaches S(STAGES) in cycle N+STAGES, and Mul_Done is asserted in that cycle only.
- The pipeline never stalls. Every stage advances every cycle, and a bubble is inserted when Iss_Mult=0.
- Arithmetic: signed DATA_W x DATA_W product; Mul_Data = product[DATA_W-1:0].
  - Partial products may be split across stages in any way, provided the result at S(STAGES) is exact.
  - Operands are registered in S1 with no combinational path to outputs.
- Flush kill condition: for an entry with tag T, kill iff Cdb_Flush && ((T - Rob_TopPtr) mod 2^TAG_W) > Cdb_RobDepth. Unsigned TAG_W-bit subtraction, so ROB wrap-around is handled.
  - Killed entries: valid cleared on the next edge, at every stage.
  - Incoming issue with Iss_Mult && Cdb_Flush: apply the same test to Iss_RobTagMul; if killed, S1 receives a bubble.
  - Last stage: Mul_Done = S(STAGES).valid && !kill(S(STAGES).tag), combinationally gated in the flush cycle.
  - Entries with difference <= Cdb_RobDepth, including the branch itself, are retained.
- When Mul_Done=0, Mul_Data, Mul_RdPhyAddr, Mul_RobTag and Mul_RegWrite hold their last values; consumers qualify them with Mul_Done.
- Mul_RegWrite is passed through unchanged. An entry with RegWrite=0 still asserts Mul_Done, so the ROB sees completion.
- Back-to-back issue: STAGES entries in flight at once, and results emerge in issue order, one per cycle.
- Mul_Busy = OR of post-flush valids of S1..S(STAGES).

Optional Feature:
- Macro: MULT_HI_EN.
- When defined:
  - Adds output Mul_DataHi (DATA_W) = product[2*DATA_W-1:DATA_W], carried with the same latency and hold rules as Mul_Data.
  - Reset value of Mul_DataHi is 0.
- When undefined: the port is absent and upper-product logic is not built.

Decomposition:
- Shared package mult_pkg:
  - constants DATA_W, TAG_W, PHY_W;
  - packed struct mult_tag_t {valid, robtag, rdphy, regwrite};
  - function rob_younger(tag, top, depth) implementing the flush compare, shared with the issue queues.
- Sub-module mult_pipe_stage:
  - one register stage with valid, tag struct, partial-product payload and flush kill;
  - instantiated STAGES times via generate.

Test Plan:
- Reset release, then issue Rs=7, Rt=6, tag=3, rd=12 in cycle 10 -> Mul_Done=1 only in cycle 14 with Data=42, RobTag=3, RdPhyAddr=12.
- Issue on 4 consecutive cycles with (-3,5), (0x10000,0x10000), (-1,-1), (0x7FFFFFFF,2) -> Done in cycles N+4..N+7 with Data 0xFFFFFFF1, 0x0, 0x1, 0xFFFFFFFE in order. With MULT_HI_EN: DataHi 0xFFFFFFFF, 0x1, 0x0, 0x0.
- Rob_TopPtr=30 with in-flight tags 31, 0, 2 (wrapped); Cdb_Flush with Cdb_RobDepth=2 -> tag 31 (diff 1) and tag 0 (diff 2) survive; tag 2 (diff 4) never asserts Mul_Done.
- Entry in S(STAGES) with tag 9, Rob_TopPtr=5, Cdb_RobDepth=1, Cdb_Flush=1 in the same cycle -> Mul_Done=0 that cycle.
- Iss_Mult and Cdb_Flush in the same cycle with Iss_RobTagMul younger than the branch -> no Mul_Done 4 cycles later; Mul_Busy stays 0 if the pipe was otherwise empty.
- Resetb pulsed low while 3 entries are in flight -> Mul_Done and Mul_Busy drop immediately and no stale result appears afterwards.
